// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter_if
// Summary  : Producer/FIFO bundle shared by the arbiter and its environment.
// Revision : 1.0
// ============================================================================
interface fifo_write_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_W       = 2
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic [ID_W+DATA_WIDTH-1:0]  fifo_din;
    logic                        fifo_write;
    logic                        fifo_full;
    logic [ID_W-1:0]             grant_id;
    logic                        busy;
    logic [31:0]                 beat_total;

    // master: producers plus FIFO environment; slave: the arbiter
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_din, fifo_write, grant_id, busy, beat_total
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_din, fifo_write, grant_id, busy, beat_total
    );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Summary  : Round-robin, burst-locked arbiter sharing one FIFO write port.
// Revision : 1.0
// ============================================================================
module fifo_write_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_W       = 2,
    parameter int BURST_MAX  = 8
) (
    input  wire logic            clk,
    input  wire logic            reset,
    fifo_write_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [7:0]      c_burst_max  = 8'(BURST_MAX);
    localparam logic [ID_W-1:0] c_last_reset = ID_W'(N_REQ - 1);

    state_t          r_state_q,      w_state_d;
    logic [ID_W-1:0] r_grant_id_q,   w_grant_id_d;
    logic [ID_W-1:0] r_last_grant_q, w_last_grant_d;
    logic [7:0]      r_burst_cnt_q,  w_burst_cnt_d;
    logic [31:0]     r_beat_total_q, w_beat_total_d;

    logic [N_REQ-1:0]      w_ready;
    logic                  w_accept;
    logic                  w_grant_valid;
    logic [DATA_WIDTH-1:0] w_payload;
    logic                  w_found;
    logic [ID_W-1:0]       w_pick;
    logic [ID_W-1:0]       w_cand;
    int                    w_idx;

    // Ready is killed by reset and by a full FIFO in the same cycle.
    always_comb begin
        w_ready = '0;
        if (!reset && (r_state_q == S_BURST) && !bus.fifo_full) begin
            w_ready[r_grant_id_q] = 1'b1;
        end
    end

    assign w_accept      = |(bus.req_valid & w_ready);
    assign w_grant_valid = bus.req_valid[r_grant_id_q];

    always_comb begin
        w_payload = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_id_q == ID_W'(i)) begin
                w_payload = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Scan upward from the requester after last_grant, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant_q;
        w_idx   = 0;
        w_cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = int'(r_last_grant_q) + i;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            w_cand = ID_W'(w_idx);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_grant_id_d   = r_grant_id_q;
        w_last_grant_d = r_last_grant_q;
        w_burst_cnt_d  = r_burst_cnt_q;
        w_beat_total_d = r_beat_total_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_id_d   = w_pick;
                    w_last_grant_d = w_pick;
                    w_burst_cnt_d  = 8'd0;
                    w_state_d      = S_BURST;
                end
            end
            S_BURST: begin
                if (w_accept) begin
                    w_burst_cnt_d  = r_burst_cnt_q + 8'd1;
                    w_beat_total_d = r_beat_total_q + 32'd1;
                end
                if ((w_accept && ((r_burst_cnt_q + 8'd1) == c_burst_max)) ||
                    !w_grant_valid) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_grant_id_q   <= '0;
            r_last_grant_q <= c_last_reset;
            r_burst_cnt_q  <= 8'd0;
            r_beat_total_q <= 32'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_grant_id_q   <= w_grant_id_d;
            r_last_grant_q <= w_last_grant_d;
            r_burst_cnt_q  <= w_burst_cnt_d;
            r_beat_total_q <= w_beat_total_d;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.fifo_write = w_accept;
    assign bus.fifo_din   = {r_grant_id_q, w_payload};
    assign bus.grant_id   = r_grant_id_q;
    assign bus.busy       = (r_state_q == S_BURST);
    assign bus.beat_total = r_beat_total_q;

endmodule
`default_nettype wire
